// File: rtl/sram_rf_xfer_engine_pkg.sv
// Shared encodings for the SRAM <-> register-file block-transfer engine.
// Holds the mode codes and the controller state type.
package sram_rf_xfer_engine_pkg;

    localparam logic [1:0] XFER_FILL  = 2'b00;
    localparam logic [1:0] XFER_LOAD  = 2'b01;
    localparam logic [1:0] XFER_STORE = 2'b10;
    localparam logic [1:0] XFER_COPY  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_FILL       = 3'd1,
        S_LOAD       = 3'd2,
        S_LOAD_DRAIN = 3'd3,
        S_STORE      = 3'd4,
        S_FIN        = 3'd5
    } xfer_state_e;

endpackage

// File: rtl/sram_rf_xfer_engine_addr_gen.sv
// Word-index counter with base+index SRAM address (wrapping) and last-word flag.
// addr_o is the address of the index the counter moves to at the next edge.
module sram_rf_xfer_engine_addr_gen #(
    parameter int SRAM_AW = 11,
    parameter int RF_AW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               step_i,
    input  logic [SRAM_AW-1:0] base_i,
    input  logic [RF_AW:0]     len_i,
    output logic [RF_AW-1:0]   idx_o,
    output logic [SRAM_AW-1:0] addr_o,
    output logic               last_o
);

    logic [RF_AW-1:0] idx_q, idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr_i) begin
            idx_d = '0;
        end else if (step_i) begin
            idx_d = idx_q + RF_AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o  = idx_q;
    assign addr_o = base_i + SRAM_AW'(idx_d);
    assign last_o = ({1'b0, idx_q} == (len_i - (RF_AW+1)'(1)));

endmodule

// File: rtl/sram_rf_xfer_engine.sv
// Block-transfer controller between the single-port SRAM and the register file:
// pattern fill, SRAM->RF load, RF->SRAM store, or copy (load then store).
module sram_rf_xfer_engine
    import sram_rf_xfer_engine_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRAM_AW = 11,
    parameter int RF_AW   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [SRAM_AW-1:0] src_base,
    input  logic [SRAM_AW-1:0] dst_base,
    input  logic [RF_AW:0]     len,
    input  logic [DATA_W-1:0]  fill_seed,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [SRAM_AW-1:0] sram_adrx,
    output logic               sram_re,
    output logic               sram_we,
    output logic [DATA_W-1:0]  sram_wdata,
    input  logic [DATA_W-1:0]  sram_rdata,
    output logic [RF_AW-1:0]   rf_rd_adrx,
    input  logic [DATA_W-1:0]  rf_rd_data,
    output logic               rf_wr_en,
    output logic [RF_AW-1:0]   rf_wr_adrx,
    output logic [DATA_W-1:0]  rf_wr_data
);

    localparam logic [RF_AW:0] LEN_MAX = {1'b1, {RF_AW{1'b0}}};

    xfer_state_e state_q, state_d;

    logic [1:0]         mode_q, mode_d;
    logic [SRAM_AW-1:0] src_q, src_d, dst_q, dst_d;
    logic [RF_AW:0]     len_q, len_d;
    logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic               re_q, re_d, we_q, we_d, rf_we_q, rf_we_d, wsel_rf_q, wsel_rf_d;
    logic [SRAM_AW-1:0] adrx_q, adrx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [RF_AW-1:0]   rf_wa_q, rf_wa_d;

    logic               ag_clr, ag_step, ag_last;
    logic [SRAM_AW-1:0] ag_base, ag_addr;
    logic [RF_AW-1:0]   ag_idx;
    logic               len_ok, start_load;

    assign len_ok     = (len != '0) && (len <= LEN_MAX);
    assign start_load = (mode == XFER_LOAD) || (mode == XFER_COPY);

    sram_rf_xfer_engine_addr_gen #(
        .SRAM_AW (SRAM_AW),
        .RF_AW   (RF_AW)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (ag_clr),
        .step_i (ag_step),
        .base_i (ag_base),
        .len_i  (len_q),
        .idx_o  (ag_idx),
        .addr_o (ag_addr),
        .last_o (ag_last)
    );

    // Address-generator control kept apart from the output logic so that
    // ag_addr feeds the output registers without a combinational cycle.
    always_comb begin
        ag_clr  = 1'b0;
        ag_step = 1'b0;
        ag_base = dst_q;
        case (state_q)
            S_IDLE: begin
                ag_clr  = 1'b1;
                ag_base = start_load ? src_base : dst_base;
            end
            S_FILL, S_STORE: ag_step = !ag_last;
            S_LOAD: begin
                ag_step = !ag_last;
                ag_base = src_q;
            end
            S_LOAD_DRAIN: ag_clr = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        err_d     = 1'b0;
        re_d      = 1'b0;
        we_d      = 1'b0;
        rf_we_d   = 1'b0;
        wsel_rf_d = 1'b0;
        adrx_d    = '0;
        wdata_d   = '0;
        rf_wa_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    src_d  = src_base;
                    dst_d  = dst_base;
                    len_d  = len;
                    if (!len_ok) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                        adrx_d = ag_addr;
                        if (mode == XFER_FILL) begin
                            state_d = S_FILL;
                            we_d    = 1'b1;
                            wdata_d = fill_seed;
                        end else if (mode == XFER_STORE) begin
                            state_d   = S_STORE;
                            we_d      = 1'b1;
                            wsel_rf_d = 1'b1;
                        end else begin
                            state_d = S_LOAD;
                            re_d    = 1'b1;
                        end
                    end
                end
            end
            S_FILL: begin
                if (ag_last) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                    we_d    = 1'b1;
                    adrx_d  = ag_addr;
                    wdata_d = wdata_q - DATA_W'(1);
                end
            end
            S_LOAD: begin
                // The word read this cycle lands in the RF next cycle.
                busy_d  = 1'b1;
                rf_we_d = 1'b1;
                rf_wa_d = ag_idx;
                if (ag_last) begin
                    state_d = S_LOAD_DRAIN;
                end else begin
                    re_d   = 1'b1;
                    adrx_d = ag_addr;
                end
            end
            S_LOAD_DRAIN: begin
                if (mode_q == XFER_COPY) begin
                    state_d   = S_STORE;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    wsel_rf_d = 1'b1;
                    adrx_d    = ag_addr;
                end else begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end
            end
            S_STORE: begin
                if (ag_last) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                end else begin
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    wsel_rf_d = 1'b1;
                    adrx_d    = ag_addr;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            rf_we_q   <= 1'b0;
            wsel_rf_q <= 1'b0;
            adrx_q    <= '0;
            wdata_q   <= '0;
            rf_wa_q   <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            re_q      <= re_d;
            we_q      <= we_d;
            rf_we_q   <= rf_we_d;
            wsel_rf_q <= wsel_rf_d;
            adrx_q    <= adrx_d;
            wdata_q   <= wdata_d;
            rf_wa_q   <= rf_wa_d;
        end
    end

    // Strobes are masked by rst so an aborted transfer cannot commit the in-flight word.
    assign sram_re    = re_q & ~rst;
    assign sram_we    = we_q & ~rst;
    assign rf_wr_en   = rf_we_q & ~rst;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign sram_adrx  = adrx_q;
    assign rf_wr_adrx = rf_wa_q;
    assign sram_wdata = wsel_rf_q ? rf_rd_data : wdata_q;
    assign rf_wr_data = rf_we_q ? sram_rdata : '0;
    assign rf_rd_adrx = (state_q == S_STORE) ? ag_idx : '0;

endmodule
